// File: rtl/mesh_ext_ingress_arb.sv
// mesh_ext_ingress_arb: packet-atomic round-robin arbiter feeding the mesh external ingress port.
// Define MESH_ARB_STATS_EN to build the per-requester saturating accepted-flit counters.
module mesh_ext_ingress_arb #(
    parameter int N_REQ   = 4,
    parameter int FLIT_W  = 64,
    parameter int MAX_GAP = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ*FLIT_W-1:0] req_flit_i,
    input  logic [N_REQ-1:0]        req_valid_i,
    input  logic [N_REQ-1:0]        req_last_i,
    output logic [N_REQ-1:0]        req_ready_o,
    output logic [FLIT_W-1:0]       ext_flit_o,
    output logic                    ext_valid_o,
    input  logic                    ext_ready_i,
    output logic [N_REQ-1:0]        grant_o,
    output logic                    busy_o,
    output logic                    gap_err_o,
    output logic [N_REQ*16-1:0]     flit_cnt_o
);
    localparam int PW = $clog2(N_REQ);
    localparam int GW = $clog2(MAX_GAP + 1);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]        state_q, state_d;
    logic [PW-1:0]     rr_q, rr_d, own_q, own_d, win, sel, nxt;
    logic [GW-1:0]     gap_q, gap_d;
    logic              gerr_q, gerr_d, vld_q, vld_d, out_free, acc;
    logic [FLIT_W-1:0] flit_q, flit_d;

    function automatic logic [PW-1:0] wrap(input int v);
        return PW'(v % N_REQ);
    endfunction

    always_comb begin
        win = rr_q;
        for (int k = N_REQ - 1; k >= 0; k--)
            if (req_valid_i[wrap(int'(rr_q) + k)]) win = wrap(int'(rr_q) + k);
    end

    assign sel         = (state_q == LOCKED) ? own_q : win;
    assign nxt         = wrap(int'(sel) + 1);
    assign out_free    = !vld_q || ext_ready_i;
    // Ready is gated by rst_n so the accept lines read zero the moment reset asserts.
    assign req_ready_o = (rst_n && out_free && (state_q == LOCKED || |req_valid_i)) ? N_REQ'(1) << sel : '0;
    assign acc         = req_valid_i[sel] && req_ready_o[sel];
    assign vld_d       = acc ? 1'b1 : (out_free ? 1'b0 : vld_q);
    assign flit_d      = acc ? req_flit_i[sel*FLIT_W +: FLIT_W] : flit_q;

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        own_d   = own_q;
        gap_d   = gap_q;
        gerr_d  = gerr_q;
        if (state_q == IDLE) begin
            if (acc && req_last_i[sel]) rr_d = nxt;
            else if (acc) begin
                state_d = LOCKED;
                own_d   = sel;
                gap_d   = '0;
            end
        end else if (acc) begin
            gap_d = '0;
            if (req_last_i[sel]) begin
                state_d = IDLE;
                rr_d    = nxt;
            end
        end else if (!req_valid_i[sel]) begin
            if (gap_q == GW'(MAX_GAP - 1)) begin
                state_d = IDLE;
                rr_d    = nxt;
                gap_d   = '0;
                gerr_d  = 1'b1;
            end else gap_d = gap_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            own_q   <= '0;
            gap_q   <= '0;
            gerr_q  <= 1'b0;
            vld_q   <= 1'b0;
            flit_q  <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            own_q   <= own_d;
            gap_q   <= gap_d;
            gerr_q  <= gerr_d;
            vld_q   <= vld_d;
            flit_q  <= flit_d;
        end
    end

    assign ext_flit_o  = flit_q;
    assign ext_valid_o = vld_q;
    assign busy_o      = state_q == LOCKED;
    assign grant_o     = busy_o ? N_REQ'(1) << own_q : '0;
    assign gap_err_o   = gerr_q;

`ifdef MESH_ARB_STATS_EN
    logic [N_REQ-1:0][15:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else
            for (int i = 0; i < N_REQ; i++)
                if (acc && sel == PW'(i) && cnt_q[i] != 16'hFFFF) cnt_q[i] <= cnt_q[i] + 16'd1;
    end
    assign flit_cnt_o = cnt_q;
`else
    assign flit_cnt_o = '0;
`endif
endmodule

// File: tb/tb_mesh_ext_ingress_arb.sv
// tb_mesh_ext_ingress_arb: directed vector table plus hand sequences for lock, backpressure, watchdog and reset.
module tb_mesh_ext_ingress_arb;
    localparam int N = 4;
    localparam int W = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N*W-1:0] req_flit;
    logic [N-1:0]   req_valid, req_last, req_ready, grant;
    logic [W-1:0]   ext_flit;
    logic           ext_valid, ext_ready, busy, gap_err;
    logic [N*16-1:0] flit_cnt;
    logic [63:0]    exp_cnt;
    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  v, l;
        logic [15:0] fl;
        logic        er;
        logic [3:0]  rdy;
        logic        ev;
        logic [15:0] ef;
        logic [3:0]  g;
        logic        b;
    } vec_t;
    vec_t tv [15];

    always #5 clk = ~clk;

    mesh_ext_ingress_arb #(.N_REQ(N), .FLIT_W(W), .MAX_GAP(32)) dut (
        .clk(clk), .rst_n(rst_n), .req_flit_i(req_flit), .req_valid_i(req_valid),
        .req_last_i(req_last), .req_ready_o(req_ready), .ext_flit_o(ext_flit),
        .ext_valid_o(ext_valid), .ext_ready_i(ext_ready), .grant_o(grant),
        .busy_o(busy), .gap_err_o(gap_err), .flit_cnt_o(flit_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] v, input logic [3:0] l, input logic [15:0] fl, input logic er);
        req_valid = v;
        req_last  = l;
        ext_ready = er;
        for (int i = 0; i < N; i++) req_flit[i*W +: W] = W'(fl + 16'(i * 256));
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tv[0]  = '{4'b0001, 4'b0000, 16'h00A0, 1'b1, 4'b0001, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tv[1]  = '{4'b0001, 4'b0000, 16'h00A1, 1'b1, 4'b0001, 1'b1, 16'h00A0, 4'b0001, 1'b1};
        tv[2]  = '{4'b0001, 4'b0001, 16'h00A2, 1'b1, 4'b0001, 1'b1, 16'h00A1, 4'b0001, 1'b1};
        tv[3]  = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 16'h00A2, 4'b0000, 1'b0};
        tv[4]  = '{4'b1111, 4'b1111, 16'h00B0, 1'b1, 4'b0010, 1'b0, 16'h0000, 4'b0000, 1'b0};
        tv[5]  = '{4'b1111, 4'b1111, 16'h00B0, 1'b1, 4'b0100, 1'b1, 16'h01B0, 4'b0000, 1'b0};
        tv[6]  = '{4'b1111, 4'b1111, 16'h00B0, 1'b1, 4'b1000, 1'b1, 16'h02B0, 4'b0000, 1'b0};
        tv[7]  = '{4'b1111, 4'b1111, 16'h00B0, 1'b1, 4'b0001, 1'b1, 16'h03B0, 4'b0000, 1'b0};
        tv[8]  = '{4'b1111, 4'b1111, 16'h00B0, 1'b1, 4'b0010, 1'b1, 16'h00B0, 4'b0000, 1'b0};
        tv[9]  = '{4'b0010, 4'b0000, 16'h00C0, 1'b1, 4'b0010, 1'b1, 16'h01B0, 4'b0000, 1'b0};
        tv[10] = '{4'b0110, 4'b0000, 16'h00C1, 1'b1, 4'b0010, 1'b1, 16'h01C0, 4'b0010, 1'b1};
        tv[11] = '{4'b0110, 4'b0000, 16'h00C2, 1'b1, 4'b0010, 1'b1, 16'h01C1, 4'b0010, 1'b1};
        tv[12] = '{4'b0110, 4'b0010, 16'h00C3, 1'b1, 4'b0010, 1'b1, 16'h01C2, 4'b0010, 1'b1};
        tv[13] = '{4'b0100, 4'b0100, 16'h00D0, 1'b1, 4'b0100, 1'b1, 16'h01C3, 4'b0000, 1'b0};
        tv[14] = '{4'b0000, 4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b1, 16'h02D0, 4'b0000, 1'b0};
`ifdef MESH_ARB_STATS_EN
        exp_cnt = 64'h0000_0005_0000_0000;
`else
        exp_cnt = 64'h0;
`endif
        drive(4'b0000, 4'b0000, 16'h0000, 1'b1);
        #1;
        chk("reset_outputs", {ext_valid, ext_flit, req_ready, grant, busy, gap_err, flit_cnt}, '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            drive(tv[k].v, tv[k].l, tv[k].fl, tv[k].er);
            #1;
            chk($sformatf("vec%0d_ctl", k), {req_ready, ext_valid, grant, busy},
                {tv[k].rdy, tv[k].ev, tv[k].g, tv[k].b});
            if (tv[k].ev) chk($sformatf("vec%0d_flit", k), ext_flit, W'(tv[k].ef));
            cyc;
        end

        drive(4'b1000, 4'b0000, 16'h00E0, 1'b1);
        #1 chk("req3_first_ready", req_ready, 4'b1000);
        cyc;
        drive(4'b1001, 4'b0000, 16'h00E1, 1'b0);
        for (int k = 0; k < 10; k++) begin
            #1;
            chk($sformatf("bp%0d", k), {ext_flit, ext_valid, req_ready, busy, gap_err},
                {W'(16'h03E0), 1'b1, 4'b0000, 1'b1, 1'b0});
            cyc;
        end
        drive(4'b0000, 4'b0000, 16'h0000, 1'b0);
        repeat (31) cyc;
        chk("gap31_locked", {busy, gap_err, grant}, {1'b1, 1'b0, 4'b1000});
        cyc;
        chk("gap32_release", {busy, gap_err, grant}, {1'b0, 1'b1, 4'b0000});
        drive(4'b1001, 4'b1001, 16'h00F0, 1'b1);
        #1 chk("after_gap_req0", req_ready, 4'b0001);
        cyc;
        chk("after_gap_flit", {ext_valid, ext_flit, gap_err}, {1'b1, W'(16'h00F0), 1'b1});

        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(4'b0100, 4'b0000, 16'(16'h0050 + k), 1'b1);
            cyc;
        end
        chk("stats_cnt", flit_cnt, exp_cnt);
        chk("stats_lock", {busy, grant, ext_flit}, {1'b1, 4'b0100, W'(16'h0254)});
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_ctl", {ext_valid, req_ready, grant, busy, gap_err}, '0);
        chk("async_reset_data", {ext_flit, flit_cnt}, '0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        drive(4'b0000, 4'b0000, 16'h0000, 1'b1);
        cyc;
        chk("no_replay", {ext_valid, busy, grant}, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
